// File: rtl/hilo_acc_bank.sv
// Multi-accumulator HI/LO register bank with plain half/full writes and a
// two-stage carry-split accumulate/subtract pipeline.
module hilo_acc_bank #(
  parameter int WIDTH    = 32,
  parameter int NUM_ACC  = 4,
  parameter int ACC_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [2:0]          wmode,
  input  logic [ACC_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]    hi_i,
  input  logic [WIDTH-1:0]    lo_i,
  input  logic [ACC_BITS-1:0] raddr,
  output logic [WIDTH-1:0]    hi_o,
  output logic [WIDTH-1:0]    lo_o,
  output logic                busy_o,
  output logic                drop_o,
  output logic                ovf_o
);

  localparam logic [2:0] OP_WR_BOTH = 3'b000;
  localparam logic [2:0] OP_WR_HI   = 3'b001;
  localparam logic [2:0] OP_WR_LO   = 3'b010;
  localparam logic [2:0] OP_ADD     = 3'b100;
  localparam logic [2:0] OP_SUB     = 3'b101;

  logic [WIDTH-1:0]    r_acc_hi [NUM_ACC];
  logic [WIDTH-1:0]    r_acc_lo [NUM_ACC];

  logic                r_s2_valid;
  logic [ACC_BITS-1:0] r_s2_addr;
  logic [WIDTH-1:0]    r_s2_lo;
  logic                r_s2_carry;
  logic [WIDTH-1:0]    r_s2_hi_a;
  logic [WIDTH-1:0]    r_s2_hi_b;
  logic                r_drop;
  logic                r_ovf;

  logic                w_sub;
  logic [WIDTH-1:0]    w_lo_b;
  logic [WIDTH:0]      w_lo_sum;
  logic [WIDTH-1:0]    w_hi_sum;
  logic                w_ovf;

  // Stage 1: low half add with carry-out; SUB is a + ~b + 1.
  assign w_sub    = (wmode == OP_SUB);
  assign w_lo_b   = w_sub ? ~lo_i : lo_i;
  assign w_lo_sum = {1'b0, r_acc_lo[waddr]} + {1'b0, w_lo_b} + {{WIDTH{1'b0}}, w_sub};

  // Stage 2: high half consumes the registered carry.
  assign w_hi_sum = r_s2_hi_a + r_s2_hi_b + {{(WIDTH-1){1'b0}}, r_s2_carry};
  assign w_ovf    = (r_s2_hi_a[WIDTH-1] == r_s2_hi_b[WIDTH-1]) &&
                    (w_hi_sum[WIDTH-1] != r_s2_hi_a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        r_acc_hi[i] <= '0;
        r_acc_lo[i] <= '0;
      end
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_lo    <= '0;
      r_s2_carry <= 1'b0;
      r_s2_hi_a  <= '0;
      r_s2_hi_b  <= '0;
      r_drop     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_drop <= we && r_s2_valid;
      r_ovf  <= 1'b0;
      if (r_s2_valid) begin
        // Any write seen this cycle is refused; only the commit happens.
        r_acc_hi[r_s2_addr] <= w_hi_sum;
        r_acc_lo[r_s2_addr] <= r_s2_lo;
        r_ovf               <= w_ovf;
        r_s2_valid          <= 1'b0;
      end else if (we) begin
        case (wmode)
          OP_WR_BOTH: begin
            r_acc_hi[waddr] <= hi_i;
            r_acc_lo[waddr] <= lo_i;
          end
          OP_WR_HI: r_acc_hi[waddr] <= hi_i;
          OP_WR_LO: r_acc_lo[waddr] <= lo_i;
          OP_ADD, OP_SUB: begin
            r_s2_valid <= 1'b1;
            r_s2_addr  <= waddr;
            r_s2_lo    <= w_lo_sum[WIDTH-1:0];
            r_s2_carry <= w_lo_sum[WIDTH];
            r_s2_hi_a  <= r_acc_hi[waddr];
            r_s2_hi_b  <= w_sub ? ~hi_i : hi_i;
          end
          default: ;
        endcase
      end
    end
  end

  assign hi_o   = r_acc_hi[raddr];
  assign lo_o   = r_acc_lo[raddr];
  assign busy_o = r_s2_valid;
  assign drop_o = r_drop;
  assign ovf_o  = r_ovf;

endmodule

// File: doc/hilo_acc_bank.md
# hilo_acc_bank

Parametrised multi-accumulator HI/LO register bank, the successor to the single HI/LO pair in the execute/write-back path. It holds NUM_ACC accumulators, each a HI and LO word of WIDTH bits. Plain writes are supported to both halves or to one half. Accumulate and subtract operations run through a two-stage carry-split pipeline so the 2·WIDTH-bit adder is off the critical path. It sits beside the register file: the write-back stage drives the write port, and the execute stage reads through the combinational read port.

## Interface
Parameters:
- WIDTH, 32, bits per HI or LO half.
- NUM_ACC, 4, number of accumulators; must be a power of two, at least 1.
- ACC_BITS, 2, index width, equal to log2(NUM_ACC); use 1 when NUM_ACC is 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset (`RstEnable` = 1).
- we  input  1  write request (`WriteEnable` = 1).
- wmode  input  3  operation: 000 WR_BOTH, 001 WR_HI, 010 WR_LO, 100 ACC_ADD, 101 ACC_SUB; all other codes are a no-op.
- waddr  input  ACC_BITS  target accumulator.
- hi_i  input  WIDTH  HI operand.
- lo_i  input  WIDTH  LO operand.
- raddr  input  ACC_BITS  read-port index.
- hi_o  output  WIDTH  HI half of acc[raddr]; combinational from registered state.
- lo_o  output  WIDTH  LO half of acc[raddr]; combinational from registered state.
- busy_o  output  1  an accumulate is in flight (stage 2 valid).
- drop_o  output  1  registered one-cycle pulse: a write was refused because busy_o was high.
- ovf_o  output  1  registered one-cycle pulse at accumulate commit: signed 2·WIDTH-bit overflow.

## Operation
- State:
  - acc_hi[NUM_ACC] and acc_lo[NUM_ACC];
  - stage-2 register s2_valid, s2_addr, s2_lo (low sum), s2_carry, s2_hi_a (old HI), s2_hi_b (HI operand, inverted for SUB), s2_sub.
- Reset: every acc_hi and acc_lo becomes 0 (`ZeroWord`). s2_valid, busy_o, drop_o and ovf_o become 0. Reset applied in the middle of an accumulate discards it, so no commit occurs.
- Plain writes, when we=1 and busy_o=0:
  - WR_BOTH loads acc_hi[waddr] from hi_i and acc_lo[waddr] from lo_i.
  - WR_HI loads acc_hi only.
  - WR_LO loads acc_lo only.
  - The other half is unchanged.
- Accumulate issue, when we=1, busy_o=0 and wmode is ADD or SUB:
  - Stage 1 computes {carry, s2_lo} = acc_lo[waddr] + (SUB ? ~lo_i : lo_i) + SUB, a WIDTH+1-bit result.
  - Stage 1 also latches the old HI, the HI operand (~hi_i for SUB) and waddr.
  - s2_valid is set to 1.
- Accumulate commit, when s2_valid=1:
  - acc_hi[s2_addr] = s2_hi_a + s2_hi_b + s2_carry, truncated to WIDTH bits.
  - acc_lo[s2_addr] = s2_lo.
  - s2_valid is cleared.
  - ovf_o pulses when the two effective operand signs are equal and the result sign differs.
- Arithmetic treats {hi,lo} as one 2·WIDTH-bit two's-complement value and wraps modulo 2^(2·WIDTH).
- Busy rule: any write with we=1 while busy_o=1 is ignored completely, including no-op codes. drop_o then pulses on the next cycle. Upstream stalls on busy_o.
- Read port: always reflects committed register contents. There is no forwarding of the in-flight accumulate, so a read of s2_addr during busy returns the pre-accumulate value.
- A no-op wmode with we=1 and busy_o=0 changes nothing and raises no pulse.
- An out-of-range index cannot occur because NUM_ACC is a power of two.

## Timing
- Plain write presented in cycle N: the value is visible on hi_o/lo_o in cycle N+1, when raddr = waddr.
- Accumulate presented in cycle N:
  - busy_o=1 in cycle N+1;
  - commit at the end of N+1;
  - result visible, busy_o=0 and ovf_o valid in cycle N+2.
- Back-to-back accumulates are possible at one every two cycles.
- When busy_o=1 in cycle N+1, a write presented in that cycle is dropped, and drop_o=1 in cycle N+2.
- Accumulate throughput is therefore one per 2 cycles; plain-write throughput is one per cycle while idle.
- rst asserted in cycle K: all outputs are 0 and all accumulators read 0 from cycle K+1. Inputs in cycle K are ignored.

## Test plan
- Reset, then WR_BOTH to acc2 with hi=0x12345678, lo=0x9ABCDEF0; read acc2 -> that pair next cycle; acc0, acc1 and acc3 read 0.
- WR_HI to acc1 with hi=0xAAAA0000, then WR_LO to acc1 with lo=0x0000BBBB -> acc1 reads hi=0xAAAA0000, lo=0x0000BBBB; each half-write leaves the other half intact.
- acc0 = {0, 0xFFFFFFFF}, then ACC_ADD {0, 1} -> busy_o high one cycle, then acc0 = {1, 0}; carry crosses the halves and ovf_o=0.
- acc3 = {0x7FFFFFFF, 0xFFFFFFFF}, then ACC_ADD {0, 1} -> acc3 = {0x80000000, 0} and ovf_o pulses. Then ACC_SUB {0, 1} -> acc3 = {0x7FFFFFFF, 0xFFFFFFFF} and ovf_o pulses again.
- ACC_ADD to acc0, immediately followed by WR_BOTH to acc1 during busy -> drop_o pulses and acc1 is unchanged. A read of acc0 during busy returns the old value.
- ACC_ADD issued, then rst asserted in the busy cycle -> no commit occurs, all accumulators read 0, and busy_o, drop_o and ovf_o are 0.
